// File: rtl/fetch_predict_if.sv
// Fetch-stage bundle: fetch/redirect/BHT-update inputs and fetch/F-D/statistics outputs.
// The master drives the inputs of the fetch stage and the slave is the fetch stage itself.
interface fetch_predict_if;
  logic        stall;
  logic [31:0] instr;
  logic [31:0] target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] pc_f;
  logic        pred_taken;
  logic        valid_d;
  logic [31:0] pc_d;
  logic        pred_taken_d;
  logic [31:0] n_branch;
  logic [31:0] n_mispredict;

  modport master (
    output stall, instr, target, redirect, redirect_pc, upd_valid, upd_pc, upd_taken,
    input  pc_f, pred_taken, valid_d, pc_d, pred_taken_d, n_branch, n_mispredict
  );

  modport slave (
    input  stall, instr, target, redirect, redirect_pc, upd_valid, upd_pc, upd_taken,
    output pc_f, pred_taken, valid_d, pc_d, pred_taken_d, n_branch, n_mispredict
  );
endinterface

// File: rtl/fetch_predict.sv
// Fetch PC sequencer with a 2-bit saturating-counter BHT. Predictions are registered into F/D,
// and execute sends back redirects and counter updates.
module fetch_predict #(
  parameter int unsigned INDEX_BITS = 6,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  fetch_predict_if.slave bus
);

  localparam int unsigned BHT_ENTRIES = 1 << INDEX_BITS;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  logic [31:0]           r_pc_f;
  logic                  r_valid_d;
  logic [31:0]           r_pc_d;
  logic                  r_pred_taken_d;
  logic [31:0]           r_n_branch;
  logic [31:0]           r_n_mispredict;
  logic [1:0]            r_bht [BHT_ENTRIES];

  logic [5:0]            w_opcode;
  logic                  w_is_uncond;
  logic                  w_is_cond;
  logic [INDEX_BITS-1:0] w_rd_idx;
  logic [INDEX_BITS-1:0] w_upd_idx;
  logic [1:0]            w_rd_ctr;
  logic [1:0]            w_upd_ctr;
  logic [1:0]            w_upd_next;
  logic                  w_pred_taken;
  logic [31:0]           w_pc_plus4;
  logic [31:0]           w_next_pc;
  logic                  w_unused_bits;

  assign w_opcode    = bus.instr[31:26];
  assign w_is_uncond = (w_opcode == OP_J)   || (w_opcode == OP_JAL);
  assign w_is_cond   = (w_opcode == OP_BEQ) || (w_opcode == OP_BNE);

  assign w_rd_idx  = r_pc_f[INDEX_BITS+1:2];
  assign w_upd_idx = bus.upd_pc[INDEX_BITS+1:2];
  assign w_rd_ctr  = r_bht[w_rd_idx];
  assign w_upd_ctr = r_bht[w_upd_idx];

  // Only the word-index bits of upd_pc select a counter; the rest alias freely.
  assign w_unused_bits = ^{bus.upd_pc[31:INDEX_BITS+2], bus.upd_pc[1:0]};

  always_comb begin
    w_pred_taken = 1'b0;
    if (w_is_uncond) begin
      w_pred_taken = 1'b1;
    end else if (w_is_cond) begin
      w_pred_taken = w_rd_ctr[1];
    end
  end

  assign w_pc_plus4 = r_pc_f + 32'd4;
  assign w_next_pc  = w_pred_taken ? bus.target : w_pc_plus4;

  always_comb begin
    w_upd_next = w_upd_ctr;
    if (bus.upd_taken) begin
      if (w_upd_ctr != 2'b11) w_upd_next = w_upd_ctr + 2'b01;
    end else begin
      if (w_upd_ctr != 2'b00) w_upd_next = w_upd_ctr - 2'b01;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc_f         <= RESET_PC;
      r_valid_d      <= 1'b0;
      r_pc_d         <= '0;
      r_pred_taken_d <= 1'b0;
    end else if (bus.redirect) begin
      // Redirect outranks stall; pc_d/pred_taken_d stay as they were.
      r_pc_f    <= bus.redirect_pc;
      r_valid_d <= 1'b0;
    end else if (!bus.stall) begin
      r_pc_f         <= w_next_pc;
      r_valid_d      <= 1'b1;
      r_pc_d         <= r_pc_f;
      r_pred_taken_d <= w_pred_taken;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
        r_bht[i] <= 2'b01;
      end
    end else if (bus.upd_valid) begin
      r_bht[w_upd_idx] <= w_upd_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_n_branch     <= '0;
      r_n_mispredict <= '0;
    end else begin
      if (bus.upd_valid) r_n_branch     <= r_n_branch + 32'd1;
      if (bus.redirect)  r_n_mispredict <= r_n_mispredict + 32'd1;
    end
  end

  assign bus.pc_f         = r_pc_f;
  assign bus.pred_taken   = w_pred_taken;
  assign bus.valid_d      = r_valid_d;
  assign bus.pc_d         = r_pc_d;
  assign bus.pred_taken_d = r_pred_taken_d;
  assign bus.n_branch     = r_n_branch;
  assign bus.n_mispredict = r_n_mispredict;

endmodule

// File: tb/tb_fetch_predict.sv
// Directed bench for fetch_predict: a vector table stepped one clock per row, followed by
// hand sequences covering PC wrap, asynchronous mid-run reset and the BHT reset value.
module tb_fetch_predict;

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;
  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] J    = 32'h0800_0000;
  localparam logic [31:0] JAL  = 32'h0C00_0000;
  localparam logic [31:0] BEQ  = 32'h1000_0000;
  localparam logic [31:0] BNE  = 32'h1400_0000;
  localparam logic [31:0] ADDI = 32'h2000_0000;
  localparam logic [31:0] BOG  = 32'hDEAD_BEE0;
  localparam int NV = 26;

  typedef struct {
    logic        stall;
    logic [31:0] instr;
    logic [31:0] target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        exp_pred;
    logic [31:0] exp_pc_f;
    logic        exp_valid_d;
    logic [31:0] exp_pc_d;
    logic        exp_pred_d;
    logic [31:0] exp_nb;
    logic [31:0] exp_nm;
  } vec_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  vec_t vecs [NV];

  fetch_predict_if bus ();

  fetch_predict #(.INDEX_BITS(6), .RESET_PC(32'h0000_0000)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic st, input logic [31:0] ins, input logic [31:0] tgt,
    input logic rd, input logic [31:0] rpc,
    input logic uv, input logic [31:0] upc, input logic ut,
    input logic ep, input logic [31:0] epc, input logic ev,
    input logic [31:0] epd, input logic epdt, input logic [31:0] enb, input logic [31:0] enm);
    vec_t v;
    v.stall = st; v.instr = ins; v.target = tgt;
    v.redirect = rd; v.redirect_pc = rpc;
    v.upd_valid = uv; v.upd_pc = upc; v.upd_taken = ut;
    v.exp_pred = ep; v.exp_pc_f = epc; v.exp_valid_d = ev;
    v.exp_pc_d = epd; v.exp_pred_d = epdt; v.exp_nb = enb; v.exp_nm = enm;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [31:0] ins, input logic [31:0] tgt,
                       input logic rd, input logic [31:0] rpc,
                       input logic uv, input logic [31:0] upc, input logic ut);
    bus.stall = st; bus.instr = ins; bus.target = tgt;
    bus.redirect = rd; bus.redirect_pc = rpc;
    bus.upd_valid = uv; bus.upd_pc = upc; bus.upd_taken = ut;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;

    vecs[0]  = mk(N, NOP, BOG,  N, 0, N, 0, N,  N, 32'h004, Y, 32'h000, N, 0, 0);
    vecs[1]  = mk(N, NOP, BOG,  N, 0, N, 0, N,  N, 32'h008, Y, 32'h004, N, 0, 0);
    vecs[2]  = mk(N, NOP, BOG,  N, 0, N, 0, N,  N, 32'h00C, Y, 32'h008, N, 0, 0);
    vecs[3]  = mk(N, J,   32'h040, N, 0, N, 0, N,  Y, 32'h040, Y, 32'h00C, Y, 0, 0);
    vecs[4]  = mk(N, J,   32'h100, N, 0, N, 0, N,  Y, 32'h100, Y, 32'h040, Y, 0, 0);
    vecs[5]  = mk(N, JAL, 32'h040, N, 0, N, 0, N,  Y, 32'h040, Y, 32'h100, Y, 0, 0);
    // Same-index update and fetch: prediction sees the old counter (01).
    vecs[6]  = mk(N, BEQ, 32'h080, N, 0, Y, 32'h040, Y,  N, 32'h044, Y, 32'h040, N, 1, 0);
    vecs[7]  = mk(N, NOP, BOG,  Y, 32'h040, N, 0, N,  N, 32'h040, N, 32'h040, N, 1, 1);
    vecs[8]  = mk(N, BEQ, 32'h080, N, 0, N, 0, N,  Y, 32'h080, Y, 32'h040, Y, 1, 1);
    vecs[9]  = mk(N, NOP, BOG,  N, 0, Y, 32'h040, Y,  N, 32'h084, Y, 32'h080, N, 2, 1);
    vecs[10] = mk(N, NOP, BOG,  N, 0, Y, 32'h040, Y,  N, 32'h088, Y, 32'h084, N, 3, 1);
    vecs[11] = mk(N, NOP, BOG,  N, 0, Y, 32'h040, Y,  N, 32'h08C, Y, 32'h088, N, 4, 1);
    vecs[12] = mk(N, NOP, BOG,  N, 0, Y, 32'h040, N,  N, 32'h090, Y, 32'h08C, N, 5, 1);
    vecs[13] = mk(N, NOP, BOG,  Y, 32'h040, N, 0, N,  N, 32'h040, N, 32'h08C, N, 5, 2);
    vecs[14] = mk(N, BNE, 32'h200, N, 0, N, 0, N,  Y, 32'h200, Y, 32'h040, Y, 5, 2);
    // 0x140 aliases 0x40 (index 16): drive the shared counter down to 00.
    vecs[15] = mk(N, NOP, BOG,  N, 0, Y, 32'h140, N,  N, 32'h204, Y, 32'h200, N, 6, 2);
    vecs[16] = mk(N, NOP, BOG,  N, 0, Y, 32'h140, N,  N, 32'h208, Y, 32'h204, N, 7, 2);
    vecs[17] = mk(N, NOP, BOG,  N, 0, Y, 32'h140, N,  N, 32'h20C, Y, 32'h208, N, 8, 2);
    vecs[18] = mk(N, NOP, BOG,  Y, 32'h040, N, 0, N,  N, 32'h040, N, 32'h208, N, 8, 3);
    vecs[19] = mk(N, BEQ, 32'h080, N, 0, N, 0, N,  N, 32'h044, Y, 32'h040, N, 8, 3);
    vecs[20] = mk(Y, NOP, BOG,  N, 0, N, 0, N,  N, 32'h044, Y, 32'h040, N, 8, 3);
    vecs[21] = mk(Y, NOP, BOG,  N, 0, N, 0, N,  N, 32'h044, Y, 32'h040, N, 8, 3);
    vecs[22] = mk(Y, NOP, BOG,  N, 0, N, 0, N,  N, 32'h044, Y, 32'h040, N, 8, 3);
    vecs[23] = mk(N, NOP, BOG,  N, 0, N, 0, N,  N, 32'h048, Y, 32'h044, N, 8, 3);
    vecs[24] = mk(Y, NOP, BOG,  Y, 32'h200, N, 0, N,  N, 32'h200, N, 32'h044, N, 8, 4);
    vecs[25] = mk(N, ADDI, 32'h999, N, 0, N, 0, N,  N, 32'h204, Y, 32'h200, N, 8, 4);

    drive(N, NOP, BOG, N, 0, N, 0, N);
    reset = 1'b1;
    #1;
    chk("reset pc_f", bus.pc_f, 32'h0);
    chk("reset valid_d", {31'b0, bus.valid_d}, 32'h0);
    chk("reset pc_d", bus.pc_d, 32'h0);
    chk("reset pred_taken_d", {31'b0, bus.pred_taken_d}, 32'h0);
    chk("reset n_branch", bus.n_branch, 32'h0);
    chk("reset n_mispredict", bus.n_mispredict, 32'h0);
    #1;
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].stall, vecs[i].instr, vecs[i].target, vecs[i].redirect,
            vecs[i].redirect_pc, vecs[i].upd_valid, vecs[i].upd_pc, vecs[i].upd_taken);
      #2;
      chk($sformatf("v%0d pred_taken", i), {31'b0, bus.pred_taken}, {31'b0, vecs[i].exp_pred});
      tick();
      chk($sformatf("v%0d pc_f", i), bus.pc_f, vecs[i].exp_pc_f);
      chk($sformatf("v%0d valid_d", i), {31'b0, bus.valid_d}, {31'b0, vecs[i].exp_valid_d});
      chk($sformatf("v%0d pc_d", i), bus.pc_d, vecs[i].exp_pc_d);
      chk($sformatf("v%0d pred_taken_d", i), {31'b0, bus.pred_taken_d}, {31'b0, vecs[i].exp_pred_d});
      chk($sformatf("v%0d n_branch", i), bus.n_branch, vecs[i].exp_nb);
      chk($sformatf("v%0d n_mispredict", i), bus.n_mispredict, vecs[i].exp_nm);
    end

    // PC wraps modulo 2^32.
    drive(N, NOP, BOG, Y, 32'hFFFF_FFFC, N, 0, N);
    tick();
    chk("wrap setup pc_f", bus.pc_f, 32'hFFFF_FFFC);
    chk("wrap setup n_mispredict", bus.n_mispredict, 32'd5);
    drive(N, NOP, BOG, N, 0, N, 0, N);
    tick();
    chk("wrap pc_f", bus.pc_f, 32'h0);
    chk("wrap pc_d", bus.pc_d, 32'hFFFF_FFFC);

    // Saturate index 16 to 11 so the reset value is observable afterwards.
    for (int k = 0; k < 3; k++) begin
      drive(N, NOP, BOG, N, 0, Y, 32'h040, Y);
      tick();
    end
    drive(N, NOP, BOG, N, 0, N, 0, N);
    chk("pre-reset pc_f", bus.pc_f, 32'h00C);
    chk("pre-reset n_branch", bus.n_branch, 32'd11);

    // Asynchronous reset pulsed between edges.
    #2;
    reset = 1'b1;
    #1;
    chk("async reset pc_f", bus.pc_f, 32'h0);
    chk("async reset valid_d", {31'b0, bus.valid_d}, 32'h0);
    chk("async reset pc_d", bus.pc_d, 32'h0);
    chk("async reset n_branch", bus.n_branch, 32'h0);
    chk("async reset n_mispredict", bus.n_mispredict, 32'h0);
    #1;
    reset = 1'b0;

    // After reset the counter is 01: BEQ not taken, then one taken update flips it.
    drive(N, NOP, BOG, Y, 32'h040, N, 0, N);
    tick();
    chk("post-reset redirect pc_f", bus.pc_f, 32'h040);
    chk("post-reset n_mispredict", bus.n_mispredict, 32'd1);
    drive(N, BEQ, 32'h080, N, 0, Y, 32'h040, Y);
    #2;
    chk("post-reset BEQ pred", {31'b0, bus.pred_taken}, 32'h0);
    tick();
    chk("post-reset BEQ pc_f", bus.pc_f, 32'h044);
    drive(N, NOP, BOG, Y, 32'h040, N, 0, N);
    tick();
    drive(N, BEQ, 32'h080, N, 0, N, 0, N);
    #2;
    chk("post-train BEQ pred", {31'b0, bus.pred_taken}, 32'h1);
    tick();
    chk("post-train BEQ pc_f", bus.pc_f, 32'h080);
    chk("post-train n_branch", bus.n_branch, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_predict.md
# fetch_predict

Fetch-stage PC sequencer with dynamic branch prediction. It holds the fetch PC and decodes the fetched instruction's opcode. It takes the extracted target address from the address-extraction stage and picks the next fetch PC using a table of 2-bit saturating counters. It also registers the prediction into the F/D pipeline register so execute can resolve it, then accepts redirect and counter-update traffic back from execute.

## Interface
Parameters:
- INDEX_BITS, 6, log2 of branch history table (BHT) entries; index = pc[INDEX_BITS+1:2]
- RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- stall  in  1  hold fetch PC and F/D register
- instr  in  32  instruction read from imem at pc_f (same cycle)
- target  in  32  extracted address for (pc_f, instr): jump/branch target, else pc_f+4
- redirect  in  1  execute detected misprediction; flush and refetch
- redirect_pc  in  32  correct next PC when redirect=1
- upd_valid  in  1  a conditional branch resolved in execute this cycle
- upd_pc  in  32  PC of the resolved branch
- upd_taken  in  1  actual outcome of the resolved branch
- pc_f  out  32  current fetch PC (to imem and address extraction)
- pred_taken  out  1  combinational: 1 when next PC selected = target
- valid_d  out  1  F/D register holds a live instruction
- pc_d  out  32  PC of instruction in F/D
- pred_taken_d  out  1  prediction made for instruction in F/D
- n_branch  out  32  count of resolved conditional branches
- n_mispredict  out  32  count of redirects

## Operation
- Opcode decode on instr[31:26]:
  - J = 6'b000010 and JAL = 6'b000011 are unconditional.
  - BEQ = 6'b000100 and BNE = 6'b000101 are conditional.
  - Everything else is sequential.
- pred_taken:
  - 1 for J/JAL.
  - For BEQ/BNE, equals bit 1 of BHT[pc_f[INDEX_BITS+1:2]].
  - 0 otherwise.
- next_pc = pred_taken ? target : pc_f + 4, using 32-bit arithmetic that wraps modulo 2^32.
- pc_f update priority, highest first:
  1. reset: pc_f = RESET_PC.
  2. redirect: pc_f = redirect_pc. Stall is ignored.
  3. stall: hold pc_f.
  4. Otherwise: pc_f = next_pc.
- F/D register:
  - On redirect: valid_d = 0. pc_d and pred_taken_d keep their old values.
  - Else on stall: hold all three.
  - Else: valid_d = 1, pc_d = pc_f, pred_taken_d = pred_taken.
- BHT:
  - 2^INDEX_BITS entries of 2 bits each. Reset sets every entry to 2'b01 (weakly not-taken).
  - On upd_valid, the entry at upd_pc[INDEX_BITS+1:2] increments if upd_taken and decrements otherwise.
  - Counters saturate at 2'b11 and 2'b00.
  - Updates occur regardless of stall or redirect.
- Counters:
  - n_branch increments on upd_valid.
  - n_mispredict increments on redirect.
  - Both wrap 32'hFFFF_FFFF to 0. Both are independent of stall.

## Timing
- Reset values:
  - pc_f = RESET_PC, valid_d = 0, pc_d = 0, pred_taken_d = 0.
  - n_branch = 0, n_mispredict = 0.
  - All BHT entries = 2'b01.
  - pred_taken follows from instr combinationally.
- Reset asserted mid-operation clears all state asynchronously, without waiting for a clock edge. State advances again on the first rising edge after deassertion.
- Fetch latency: a new pc_f appears one edge after selection. Every non-stalled, non-redirected cycle produces exactly one F/D entry.
- BHT read is combinational on pc_f. A write is visible from the following cycle only. If upd_pc and pc_f hit the same index in one cycle, prediction uses the pre-update value (no bypass).
- Redirect and upd_valid in the same cycle are both applied.
- Redirect together with stall: the redirect wins, and the F/D register is flushed.
- Aliasing across PCs sharing an index is permitted. No tag check is performed.

## Test plan
- Reset then run, no stall, instr = NOP (32'h0): pc_f goes 0 -> 4 -> 8 -> C. valid_d = 1 from the first edge. pc_d trails pc_f by one cycle.
- Jump: pc_f = 32'h40, instr = J, target = 32'h100 -> pred_taken = 1 and next pc_f = 32'h100. BEQ at the same PC with a fresh BHT -> pred_taken = 0 and next pc_f = 32'h44.
- Training: upd_valid with upd_pc = 32'h40 and upd_taken = 1, applied once -> entry 2'b10. Next BEQ fetched at 32'h40 predicts taken. Three more taken updates keep the entry at 2'b11; one not-taken update -> 2'b10, still predicting taken.
- Redirect: redirect = 1 with redirect_pc = 32'h200 while stall = 1 -> pc_f = 32'h200 and valid_d = 0 next cycle; n_mispredict = 1.
- Stall: stall held 3 cycles -> pc_f, pc_d and valid_d unchanged. Releasing stall resumes at pc_f + 4.
- Wrap and mid-run reset: pc_f = 32'hFFFF_FFFC with NOP -> next pc_f = 0. Async reset pulsed between edges -> pc_f = RESET_PC before the next edge, and n_branch = 0.
